// File: rtl/mux_key.sv
// Key-matched lookup mux: returns the data of the table pair whose key equals `key`, else DEFAULT.
// Latency: out/hit are combinational (0 cycles); out_q/hit_q are the same result one clk later.
// Backpressure: none; the lookup is evaluated every cycle and the registers capture every edge.
//
// Ports:
//   clk    clock for the registered copy only
//   rst    synchronous active-high reset, clears out_q/hit_q only
//   key    select value compared exactly against every table key
//   lut    NR_KEY packed {key,data} pairs; pair i occupies [(i+1)*W-1 : i*W], key in the upper bits
//   out    combinational lookup result (DEFAULT on miss)
//   hit    combinational: at least one table key equals key
//   out_q  out registered on clk
//   hit_q  hit registered on clk
module mux_key #(
  parameter int                  NR_KEY   = 2,
  parameter int                  KEY_LEN  = 1,
  parameter int                  DATA_LEN = 1,
  parameter logic [DATA_LEN-1:0] DEFAULT  = '0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [KEY_LEN-1:0]                   key,
  input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut,
  output logic [DATA_LEN-1:0]                  out,
  output logic                                 hit,
  output logic [DATA_LEN-1:0]                  out_q,
  output logic                                 hit_q
);

  localparam int W = KEY_LEN + DATA_LEN;

  // Scan from index 0 upward so a later (higher-index) match overwrites an
  // earlier one: with duplicate keys the first-written pair, which lands at
  // the MSB end of a concatenation, is the one that wins. Data is never OR-merged.
  always_comb begin
    out = DEFAULT;
    hit = 1'b0;
    for (int i = 0; i < NR_KEY; i++) begin
      if (lut[i*W + DATA_LEN +: KEY_LEN] == key) begin
        out = lut[i*W +: DATA_LEN];
        hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
      hit_q <= 1'b0;
    end else begin
      out_q <= out;
      hit_q <= hit;
    end
  end

endmodule

// File: tb/tb_mux_key.sv
module tb_mux_key;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  // ---- tables ----
  localparam logic [39:0]  T1 = {2'b00, 8'hAA, 2'b01, 8'hBB, 2'b10, 8'hCC, 2'b11, 8'hDD};
  localparam logic [53:0]  T2 = {2'b00, 16'h1111, 2'b01, 16'h2222, 2'b10, 16'h3333};
  localparam logic [174:0] T3 = {3'b000, 32'h1111_0000, 3'b001, 32'h2222_1111, 3'b010, 32'h3333_2222,
                                 3'b100, 32'h4444_3333, 3'b101, 32'h5555_4444};
  localparam logic [19:0]  TD = {2'b01, 8'h11, 2'b01, 8'h22};
  localparam logic [6:0]   TS = {3'b110, 4'h9};

  // ---- DUT 0: 4 x (2,8) ----
  logic [1:0]  k0;  logic [39:0]  l0;  logic [7:0]  o0, oq0;  logic h0, hq0;
  mux_key #(.NR_KEY(4), .KEY_LEN(2), .DATA_LEN(8)) u0 (
    .clk(clk), .rst(rst), .key(k0), .lut(l0), .out(o0), .hit(h0), .out_q(oq0), .hit_q(hq0));

  // ---- DUT 1: 3 x (2,16) ----
  logic [1:0]  k1;  logic [53:0]  l1;  logic [15:0] o1, oq1; logic h1, hq1;
  mux_key #(.NR_KEY(3), .KEY_LEN(2), .DATA_LEN(16)) u1 (
    .clk(clk), .rst(rst), .key(k1), .lut(l1), .out(o1), .hit(h1), .out_q(oq1), .hit_q(hq1));

  // ---- DUT 2: 5 x (3,32) MemOp table ----
  logic [2:0]  k2;  logic [174:0] l2;  logic [31:0] o2, oq2; logic h2, hq2;
  mux_key #(.NR_KEY(5), .KEY_LEN(3), .DATA_LEN(32)) u2 (
    .clk(clk), .rst(rst), .key(k2), .lut(l2), .out(o2), .hit(h2), .out_q(oq2), .hit_q(hq2));

  // ---- DUT 3: duplicate keys, 2 x (2,8) ----
  logic [1:0]  k3;  logic [19:0]  l3;  logic [7:0]  o3, oq3;  logic h3, hq3;
  mux_key #(.NR_KEY(2), .KEY_LEN(2), .DATA_LEN(8)) u3 (
    .clk(clk), .rst(rst), .key(k3), .lut(l3), .out(o3), .hit(h3), .out_q(oq3), .hit_q(hq3));

  // ---- DUT 4: single entry, non-zero default ----
  logic [2:0]  k4;  logic [6:0]   l4;  logic [3:0]  o4, oq4;  logic h4, hq4;
  mux_key #(.NR_KEY(1), .KEY_LEN(3), .DATA_LEN(4), .DEFAULT(4'h5)) u4 (
    .clk(clk), .rst(rst), .key(k4), .lut(l4), .out(o4), .hit(h4), .out_q(oq4), .hit_q(hq4));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference for DUT 0: search from the highest index down, first match returns.
  function automatic logic [8:0] ref0(input logic [39:0] l, input logic [1:0] k);
    for (int i = 3; i >= 0; i--)
      if (l[i*10+8 +: 2] == k) return {1'b1, l[i*10 +: 8]};
    return 9'h0;
  endfunction

  typedef struct {
    int unsigned  dut;
    logic [2:0]   key;
    logic [174:0] lut;
    logic [31:0]  exp_out;
    logic         exp_hit;
    string        name;
  } vec_t;

  vec_t vecs[15];

  // Scoreboard for the registered path: {hit_q, out_q} expected after the next edge.
  logic [8:0] sb[$];

  task automatic reg_step(input logic r, input logic [1:0] k, input string nm);
    logic [8:0] e;
    @(negedge clk);
    rst = r;
    k0  = k;
    #1;
    e = ref0(l0, k);
    chk({nm, "_out"}, 32'(o0), 32'(e[7:0]));
    chk({nm, "_hit"}, 32'(h0), 32'(e[8]));
    sb.push_back(r ? 9'h0 : e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({nm, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({nm, "_out_q"}, 32'(oq0), 32'(e[7:0]));
      chk({nm, "_hit_q"}, 32'(hq0), 32'(e[8]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{0, 3'b010, 175'(T1), 32'h0000_00CC, 1'b1, "t1_k10"};
    vecs[1]  = '{0, 3'b000, 175'(T1), 32'h0000_00AA, 1'b1, "t1_k00"};
    vecs[2]  = '{0, 3'b011, 175'(T1), 32'h0000_00DD, 1'b1, "t1_k11"};
    vecs[3]  = '{1, 3'b011, 175'(T2), 32'h0000_0000, 1'b0, "t2_k11_miss"};
    vecs[4]  = '{1, 3'b001, 175'(T2), 32'h0000_2222, 1'b1, "t2_k01"};
    vecs[5]  = '{1, 3'b010, 175'(T2), 32'h0000_3333, 1'b1, "t2_k10"};
    vecs[6]  = '{2, 3'b100, T3,       32'h4444_3333, 1'b1, "t3_k100"};
    vecs[7]  = '{2, 3'b011, T3,       32'h0000_0000, 1'b0, "t3_k011_miss"};
    vecs[8]  = '{2, 3'b000, T3,       32'h1111_0000, 1'b1, "t3_k000"};
    vecs[9]  = '{2, 3'b111, T3,       32'h0000_0000, 1'b0, "t3_k111_miss"};
    vecs[10] = '{3, 3'b001, 175'(TD), 32'h0000_0011, 1'b1, "dup_k01"};
    vecs[11] = '{3, 3'b000, 175'(TD), 32'h0000_0000, 1'b0, "dup_k00_miss"};
    vecs[12] = '{4, 3'b110, 175'(TS), 32'h0000_0009, 1'b1, "one_k110"};
    vecs[13] = '{4, 3'b111, 175'(TS), 32'h0000_0005, 1'b0, "one_k111_dflt"};
    vecs[14] = '{4, 3'b010, 175'(TS), 32'h0000_0005, 1'b0, "one_k010_dflt"};

    k0 = '0; l0 = T1; k1 = '0; l1 = T2; k2 = '0; l2 = T3; k3 = '0; l3 = TD; k4 = '0; l4 = TS;

    // Combinational table vectors.
    for (int i = 0; i < 15; i++) begin
      logic [31:0] ao;
      logic        ah;
      case (vecs[i].dut)
        0: begin k0 = vecs[i].key[1:0]; l0 = vecs[i].lut[39:0];  end
        1: begin k1 = vecs[i].key[1:0]; l1 = vecs[i].lut[53:0];  end
        2: begin k2 = vecs[i].key;      l2 = vecs[i].lut;        end
        3: begin k3 = vecs[i].key[1:0]; l3 = vecs[i].lut[19:0];  end
        default: begin k4 = vecs[i].key; l4 = vecs[i].lut[6:0]; end
      endcase
      #1;
      case (vecs[i].dut)
        0: begin ao = 32'(o0); ah = h0; end
        1: begin ao = 32'(o1); ah = h1; end
        2: begin ao = o2;      ah = h2; end
        3: begin ao = 32'(o3); ah = h3; end
        default: begin ao = 32'(o4); ah = h4; end
      endcase
      chk({vecs[i].name, "_out"}, ao, vecs[i].exp_out);
      chk({vecs[i].name, "_hit"}, 32'(ah), 32'(vecs[i].exp_hit));
    end

    // Registered path: reset hold, release, re-assert, release again.
    l0 = T1;
    reg_step(1'b1, 2'b11, "rst_edge1");
    reg_step(1'b1, 2'b11, "rst_edge2");
    reg_step(1'b0, 2'b11, "release_k11");
    reg_step(1'b0, 2'b01, "run_k01");
    reg_step(1'b1, 2'b10, "rst_mid");
    reg_step(1'b0, 2'b00, "release_k00");

    // Random tables (including forced duplicates), full key sweep on both paths.
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      l0 = {$urandom, $urandom_range(255, 0)};
      if (t % 2 == 1) l0[39:38] = l0[9:8];
      for (int k = 0; k < 4; k++)
        reg_step(1'b0, 2'(k), $sformatf("rand%0d_k%0d", t, k));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
